stream_gen: RTL and testbench
=============================

Name: stream_gen

Overview:
- Upstream traffic source for the checker path (skid buffer followed by checker logic).
- Emits a valid/ready stream of DW-bit words in bursts of BURST_LEN beats, with GAP_LEN idle cycles between bursts, for NUM_BURSTS bursts per start command.
- Payload is either an incrementing count or a 16-bit LFSR sequence, so the downstream checker can predict every word.
- Must tolerate arbitrary ready back-pressure with no data loss or duplication.

Parameters:
- DW, 16, data width; must be >= 16.
- BURST_LEN, 8, beats per burst; must be >= 1.
- GAP_LEN, 2, idle cycles between bursts; 0 allowed, meaning back-to-back bursts.
- NUM_BURSTS, 4, bursts per run; must be >= 1.
- SEED, 16'hACE1, LFSR start value; must be nonzero.

Ports:
- clk  input  1  clock; all logic on the rising edge
- rst  input  1  synchronous, active-high reset
- start_i  input  1  one-cycle run request; honoured only in IDLE
- mode_i  input  1  0 = incrementing payload, 1 = LFSR payload; sampled on an accepted start
- ready_i  input  1  downstream ready
- valid_o  output  1  data_o is valid
- data_o  output  DW  payload word
- busy_o  output  1  high from the cycle after an accepted start until the return to IDLE
- done_o  output  1  one-cycle pulse after the final beat is accepted
- beats_o  output  32  beats accepted since reset; wraps at 2^32

Behaviour:
- Reset (rst=1 at a clock edge) forces:
  - state=IDLE
  - valid_o=0, data_o=0, busy_o=0, done_o=0, beats_o=0
  - burst and gap counters = 0
  - mode register = 0
- Reset mid-run aborts at once: the current beat is dropped, and the next start begins from the initial payload again.
- Handshake rules:
  - A beat transfers in any cycle with valid_o && ready_i.
  - Once valid_o rises, valid_o and data_o stay stable until that transfer.
  - valid_o never depends combinationally on ready_i.
- Registered outputs: valid_o, data_o, busy_o, done_o, beats_o are all flops.
- State machine:
  - IDLE, start_i=1: latch mode_i and load the payload (0 for incrementing, SEED zero-extended for LFSR). Go to BURST. valid_o=1 on the next cycle, so first valid is 1 cycle after start.
  - BURST: valid_o=1. On each transfer, advance the payload and the beat-in-burst counter.
    - On the transfer of beat BURST_LEN: if the burst is the last one, go to IDLE with done_o=1 for one cycle and busy_o=0. Otherwise go to GAP (if GAP_LEN>0) or stay in BURST (if GAP_LEN=0).
    - On the state exit, valid_o drops in the same registered update.
  - GAP: valid_o=0 for exactly GAP_LEN cycles, then BURST.
- start_i while not in IDLE is ignored; it is not queued.
- Payload advance:
  - Incrementing: data_o + 1, modulo 2^DW.
  - LFSR: low 16 bits shift left by 1, with bit0 = d[15]^d[13]^d[12]^d[10]. Bits above 15 stay 0.
- Payload persistence: the payload does not reset between bursts within a run. Each new run restarts from its initial value.
- beats_o increments by 1 on every transfer, including across runs.
- Simultaneous events:
  - Final-beat transfer and start_i in the same cycle: start_i is ignored, because the state is not IDLE at that edge.
  - Beat count per run = BURST_LEN*NUM_BURSTS exactly, independent of the ready_i pattern.

Test Plan:
- Reset, ready_i=1, mode 0, start pulse at cycle 5 with defaults:
  - valid_o rises at cycle 6.
  - data_o = 0..7; valid_o low for 2 cycles; then 8..15, 16..23, 24..31.
  - done_o pulses one cycle after word 31 transfers; beats_o=32.
- Mode 1, ready_i=1, defaults:
  - first words are 16'hACE1 then 16'h59C3, following the tap formula.
  - 32 words total; the word sequence matches an identical software LFSR.
- ready_i random at 30% high, mode 0:
  - data_o/valid_o are held stable on every stall cycle.
  - Received sequence is exactly 0..31, with no gaps and no repeats; done_o fires once.
- GAP_LEN=0, BURST_LEN=1, NUM_BURSTS=3, ready_i=1:
  - valid_o high for 3 consecutive cycles carrying 0, 1, 2; then done_o.
- start_i pulsed again mid-run and in the cycle of the final transfer: no effect. A start one cycle after done_o begins a new run at data 0.
- rst asserted during beat 5 with ready_i=0:
  - next cycle valid_o=0, busy_o=0, beats_o=0.
  - a following start restarts from data 0 (or from SEED in mode 1).

Source files
------------

// File: rtl/stream_gen.sv
// stream_gen: valid/ready traffic source that emits NUM_BURSTS bursts of BURST_LEN beats,
// separated by GAP_LEN idle cycles, carrying an incrementing or 16-bit LFSR payload.
module stream_gen #(
   parameter int unsigned DW         = 16,
   parameter int unsigned BURST_LEN  = 8,
   parameter int unsigned GAP_LEN    = 2,
   parameter int unsigned NUM_BURSTS = 4,
   parameter logic [15:0] SEED       = 16'hACE1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start_i,
   input  logic          mode_i,
   input  logic          ready_i,
   output logic          valid_o,
   output logic [DW-1:0] data_o,
   output logic          busy_o,
   output logic          done_o,
   output logic [31:0]   beats_o
);

   localparam int unsigned BCW = $clog2(BURST_LEN + 1);
   localparam int unsigned NCW = $clog2(NUM_BURSTS + 1);
   localparam int unsigned GCW = $clog2(GAP_LEN + 2);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BURST = 2'd1,
      GAP   = 2'd2
   } state_t;

   state_t         state;
   logic           mode_q;
   logic [BCW-1:0] beat_cnt;
   logic [NCW-1:0] burst_cnt;
   logic [GCW-1:0] gap_cnt;

   logic           xfer;
   logic           last_beat;
   logic           last_burst;
   logic           last_gap;
   logic [15:0]    lfsr_next;
   logic [DW-1:0]  payload_next;

   // Handshake and end-of-segment decodes; ready_i only feeds registered updates.
   assign xfer         = valid_o && ready_i;
   assign last_beat    = (beat_cnt == BCW'(BURST_LEN - 1));
   assign last_burst   = (burst_cnt == NCW'(NUM_BURSTS - 1));
   assign last_gap     = (gap_cnt == GCW'(GAP_LEN - 1));
   assign lfsr_next    = {data_o[14:0], data_o[15] ^ data_o[13] ^ data_o[12] ^ data_o[10]};
   assign payload_next = mode_q ? DW'(lfsr_next) : data_o + DW'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         valid_o   <= 1'b0;
         data_o    <= '0;
         busy_o    <= 1'b0;
         done_o    <= 1'b0;
         beats_o   <= '0;
         beat_cnt  <= '0;
         burst_cnt <= '0;
         gap_cnt   <= '0;
         mode_q    <= 1'b0;
      end else begin
         done_o <= 1'b0;
         if (xfer) begin
            beats_o <= beats_o + 32'd1;
         end

         case (state)
            IDLE: begin
               if (start_i) begin
                  mode_q    <= mode_i;
                  data_o    <= mode_i ? DW'(SEED) : '0;
                  valid_o   <= 1'b1;
                  busy_o    <= 1'b1;
                  beat_cnt  <= '0;
                  burst_cnt <= '0;
                  gap_cnt   <= '0;
                  state     <= BURST;
               end
            end

            BURST: begin
               if (xfer) begin
                  data_o <= payload_next;
                  if (last_beat) begin
                     beat_cnt <= '0;
                     if (last_burst) begin
                        state   <= IDLE;
                        valid_o <= 1'b0;
                        busy_o  <= 1'b0;
                        done_o  <= 1'b1;
                     end else begin
                        burst_cnt <= burst_cnt + NCW'(1);
                        // With no gap the next burst follows directly and valid_o stays high.
                        if (GAP_LEN != 0) begin
                           state   <= GAP;
                           valid_o <= 1'b0;
                           gap_cnt <= '0;
                        end
                     end
                  end else begin
                     beat_cnt <= beat_cnt + BCW'(1);
                  end
               end
            end

            GAP: begin
               if (last_gap) begin
                  state   <= BURST;
                  valid_o <= 1'b1;
                  gap_cnt <= '0;
               end else begin
                  gap_cnt <= gap_cnt + GCW'(1);
               end
            end

            default: begin
               state   <= IDLE;
               valid_o <= 1'b0;
               busy_o  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_stream_gen.sv
// tb_stream_gen: checks stream_gen timing, payload sequences, back-pressure and reset abort
// against a word-index reference model; a short-burst instance is checked from a vector table.
module tb_stream_gen;

   localparam int unsigned DW    = 16;
   localparam int unsigned BL    = 8;
   localparam int unsigned GL    = 2;
   localparam int unsigned NB    = 4;
   localparam logic [15:0] SEED  = 16'hACE1;
   localparam int unsigned TOTAL = BL * NB;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, start, mode, ready;
   logic          valid, busy, done;
   logic [DW-1:0] data;
   logic [31:0]   beats;

   logic          start2, mode2, ready2;
   logic          valid2, busy2, done2;
   logic [15:0]   data2;
   logic [31:0]   beats2;

   stream_gen #(.DW(DW), .BURST_LEN(BL), .GAP_LEN(GL), .NUM_BURSTS(NB), .SEED(SEED)) dut (
      .clk(clk), .rst(rst), .start_i(start), .mode_i(mode), .ready_i(ready),
      .valid_o(valid), .data_o(data), .busy_o(busy), .done_o(done), .beats_o(beats)
   );

   stream_gen #(.DW(16), .BURST_LEN(1), .GAP_LEN(0), .NUM_BURSTS(3), .SEED(SEED)) dut2 (
      .clk(clk), .rst(rst), .start_i(start2), .mode_i(mode2), .ready_i(ready2),
      .valid_o(valid2), .data_o(data2), .busy_o(busy2), .done_o(done2), .beats_o(beats2)
   );

   int          checks   = 0;
   int          failures = 0;
   int unsigned mbeats   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Software Fibonacci LFSR: feedback is the XOR of the tapped bits, shifted in at bit 0.
   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      int  taps [4] = '{15, 13, 12, 10};
      logic fb = 1'b0;
      foreach (taps[i]) fb ^= s[taps[i]];
      return {s[14:0], fb};
   endfunction

   // Expected k-th word of a run (k counts from 0 at the run start).
   function automatic logic [15:0] word(input logic m, input int unsigned k);
      logic [15:0] s;
      if (!m) return 16'(k);
      s = SEED;
      for (int unsigned i = 0; i < k; i++) s = lfsr_step(s);
      return s;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Ready held high: exact per-cycle valid/data/gap/done timing of a full run.
   task automatic run_full(input logic m);
      int unsigned k = 0;
      chk("pre_start_valid", 32'(valid), 32'd0);
      start = 1'b1; mode = m; ready = 1'b1;
      tick();
      start = 1'b0;
      for (int b = 0; b < int'(NB); b++) begin
         for (int i = 0; i < int'(BL); i++) begin
            chk("full_valid", 32'(valid), 32'd1);
            chk("full_busy", 32'(busy), 32'd1);
            chk("full_data", 32'(data), 32'(word(m, k)));
            k++;
            mbeats++;
            tick();
         end
         if (b != int'(NB) - 1) begin
            for (int g = 0; g < int'(GL); g++) begin
               chk("gap_valid", 32'(valid), 32'd0);
               chk("gap_busy", 32'(busy), 32'd1);
               tick();
            end
         end
      end
      chk("full_done", 32'(done), 32'd1);
      chk("full_busy_end", 32'(busy), 32'd0);
      chk("full_valid_end", 32'(valid), 32'd0);
      chk("full_beats", beats, 32'(mbeats));
      tick();
      chk("full_done_pulse", 32'(done), 32'd0);
   endtask

   // Random ready at ~30%: stall stability, exact in-order delivery, one done pulse.
   task automatic run_random(input logic m);
      int unsigned idx   = 0;
      int          dones = 0;
      logic        stalled = 1'b0;
      logic [15:0] held = '0;
      start = 1'b1; mode = m; ready = 1'b0;
      tick();
      start = 1'b0;
      for (int cyc = 0; cyc < 3000 && dones == 0; cyc++) begin
         if (stalled) begin
            chk("stall_valid", 32'(valid), 32'd1);
            chk("stall_data", 32'(data), 32'(held));
         end
         ready = ($urandom_range(0, 9) < 3);
         if (valid && ready) begin
            chk("rand_data", 32'(data), 32'(word(m, idx)));
            idx++;
            mbeats++;
         end
         stalled = valid && !ready;
         held    = data;
         tick();
         chk("rand_beats", beats, 32'(mbeats));
         if (done) dones++;
      end
      chk("rand_count", 32'(idx), 32'(TOTAL));
      for (int i = 0; i < 6; i++) begin
         ready = 1'(($urandom_range(0, 1)));
         tick();
         if (done) dones++;
         chk("rand_idle_valid", 32'(valid), 32'd0);
      end
      chk("rand_done_once", 32'(dones), 32'd1);
   endtask

   typedef struct {
      logic        start;
      logic        ready;
      logic        valid;
      logic [15:0] data;
      logic        busy;
      logic        done;
      logic [31:0] beats;
   } vec_t;

   initial begin
      // Short-burst instance (1 beat x 3 bursts, no gap); inputs apply before an edge,
      // expectations are sampled just after it.  Starts in rows 1-3 land mid-run.
      vec_t tbl [11];
      tbl[0]  = '{1'b1, 1'b1, 1'b1, 16'd0, 1'b1, 1'b0, 32'd0};
      tbl[1]  = '{1'b1, 1'b1, 1'b1, 16'd1, 1'b1, 1'b0, 32'd1};
      tbl[2]  = '{1'b1, 1'b1, 1'b1, 16'd2, 1'b1, 1'b0, 32'd2};
      tbl[3]  = '{1'b1, 1'b1, 1'b0, 16'd3, 1'b0, 1'b1, 32'd3};
      tbl[4]  = '{1'b1, 1'b0, 1'b1, 16'd0, 1'b1, 1'b0, 32'd3};
      tbl[5]  = '{1'b0, 1'b0, 1'b1, 16'd0, 1'b1, 1'b0, 32'd3};
      tbl[6]  = '{1'b0, 1'b1, 1'b1, 16'd1, 1'b1, 1'b0, 32'd4};
      tbl[7]  = '{1'b0, 1'b1, 1'b1, 16'd2, 1'b1, 1'b0, 32'd5};
      tbl[8]  = '{1'b0, 1'b1, 1'b0, 16'd3, 1'b0, 1'b1, 32'd6};
      tbl[9]  = '{1'b0, 1'b0, 1'b0, 16'd3, 1'b0, 1'b0, 32'd6};
      tbl[10] = '{1'b1, 1'b1, 1'b1, 16'd0, 1'b1, 1'b0, 32'd6};

      rst = 1'b1; start = 1'b0; mode = 1'b0; ready = 1'b0;
      start2 = 1'b0; mode2 = 1'b0; ready2 = 1'b0;
      repeat (3) tick();
      chk("rst_valid", 32'(valid), 32'd0);
      chk("rst_data", 32'(data), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_beats", beats, 32'd0);
      rst = 1'b0;
      repeat (2) tick();
      chk("idle_valid", 32'(valid), 32'd0);

      foreach (tbl[i]) begin
         start2 = tbl[i].start;
         ready2 = tbl[i].ready;
         tick();
         chk($sformatf("vec%0d_valid", i), 32'(valid2), 32'(tbl[i].valid));
         if (tbl[i].valid) chk($sformatf("vec%0d_data", i), 32'(data2), 32'(tbl[i].data));
         chk($sformatf("vec%0d_busy", i), 32'(busy2), 32'(tbl[i].busy));
         chk($sformatf("vec%0d_done", i), 32'(done2), 32'(tbl[i].done));
         chk($sformatf("vec%0d_beats", i), beats2, tbl[i].beats);
      end
      start2 = 1'b0;

      run_full(1'b0);
      tick();
      run_full(1'b1);
      tick();
      run_random(1'b0);
      run_random(1'($urandom_range(0, 1)));

      // Reset with beat 5 on the bus and ready low aborts the run.
      start = 1'b1; mode = 1'b0; ready = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 20 && data != 16'd5; i++) tick();
      chk("abort_reached_beat5", 32'(data), 32'd5);
      ready = 1'b0; rst = 1'b1;
      tick();
      rst = 1'b0;
      mbeats = 0;
      chk("abort_valid", 32'(valid), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_beats", beats, 32'd0);
      chk("abort_data", 32'(data), 32'd0);
      tick();
      start = 1'b1; mode = 1'b1; ready = 1'b1;
      tick();
      start = 1'b0;
      chk("restart_seed", 32'(data), 32'h0000ACE1);
      tick();
      chk("restart_lfsr2", 32'(data), 32'h000059C3);
      chk("restart_beats", beats, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
